luma_flux_scheduler: RTL and testbench
======================================

# luma_flux_scheduler

Round-robin flux scheduler for the multi-flux HEVC luma interpolation actors. It decides which tagged data flux (0..FLUX-1) the coefficient/filter actor serves, replacing the actors' fixed lowest-index-first tag choice. That fixed choice starves high tags under load. The scheduler holds a flux for a bounded burst of firings, then rotates. It sits beside the actor and drives its tag selection from registered state.

## Interface
Parameters:
- FLUX, 2: number of tagged fluxes, ≥1.
- BURST, 4: maximum firings per grant, ≥1.
- TAG_WIDTH, max(1,$clog2(FLUX)): derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req  in  FLUX  per-flux eligibility. req[i] = alpha FIFO i non-empty AND all eight coefficient FIFOs i non-full, combinational from the FIFO flags.
- fire  in  1  the actor fired one token on the granted flux this cycle.
- grant  out  FLUX  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  a grant is held.
- tag  out  TAG_WIDTH  binary index of grant; 0 when idle.
- err  out  1  sticky protocol-violation flag.

## Operation
- State machine IDLE / HOLD. Internal registers:
  - g: granted index.
  - cnt: remaining burst, width $clog2(BURST+1).
  - last: last released flux.
- Round-robin pick: search req starting at index last+1 (mod FLUX), wrapping, ending at last. The first set bit wins, so last has lowest priority.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: go to HOLD with g = pick, cnt = BURST.
- HOLD, fire && req[g]: cnt decrements.
- Release condition R = (fire && req[g] && cnt==1) || !req[g].
- On R:
  - last = g.
  - Re-pick immediately, using the updated last.
  - If a winner exists: stay in HOLD with the new g and cnt = BURST. The winner can be the same flux only when it is the sole requester.
  - Otherwise go to IDLE.
- Actor contract: the actor fires only when grant_valid && req[tag].
- Violations set err and are otherwise ignored (no cnt or state change):
  - fire while in IDLE.
  - fire while !req[g].
- err clears only on reset.
- FLUX=1: pick is always 0, and the burst counter still runs.

## Timing
- Reset values:
  - grant=0, grant_valid=0, tag=0, err=0.
  - State IDLE, cnt=0.
  - last=FLUX-1, so flux 0 wins first.
- Reset asserted mid-burst: all outputs return to reset values on the next edge. The burst is abandoned with no further effect.
- Grant latency: req sampled at edge t in IDLE → grant_valid high in cycle t+1.
- Burst switch: no bubble. The final fire at edge t → new grant visible in cycle t+1, fireable in the same cycle.
- Eligibility loss without fire: release at the same edge.
- grant, tag, grant_valid are pure register outputs. There is no combinational path from req or fire.
- Sustained throughput: one firing per cycle whenever any flux is eligible, except the single entry cycle from IDLE.

## Structure
- Package luma_sched_pkg:
  - typedef enum logic {IDLE, HOLD} sched_state_t.
  - Function onehot_to_idx, for the tag/grant consistency assertion.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req, last.
  - Outputs: found, idx.
  - Instantiated once and reused for both the IDLE pick and the re-pick on release.
- Assertions:
  - grant is one-hot or zero.
  - grant == (1<<tag) when grant_valid.
  - cnt ≤ BURST.

## Test plan
1. Reset: hold reset 3 cycles with req=2'b11 → grant=0, grant_valid=0, tag=0, err=0 throughout. First grant after release is flux 0.
2. FLUX=2, BURST=4, req=2'b11 constant, fire whenever grant_valid → tag sequence 0,0,0,0,1,1,1,1,0… with no idle cycle between bursts.
3. req=2'b01, fire twice, then req=2'b00 → release at that edge, grant_valid=0 next cycle. Then req=2'b11 → flux 1 granted (last=0).
4. Sole requester: req=2'b10, continuous fire for 10 cycles → flux 1 re-granted after each burst, 10 fires, no gap.
5. fire=1 while grant_valid=0 → err=1 and stays 1. State stays IDLE. Reset clears err.
6. Reset mid-burst: in HOLD on flux 1 with cnt=2, assert reset for 1 cycle with req=2'b11 → outputs reset next cycle, then flux 0 granted with a full BURST.

Source files
------------

// File: rtl/luma_sched_pkg.sv
// Shared types and helpers for the round-robin luma flux scheduler.
package luma_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    // Binary index of the highest set bit; used to cross-check grant against tag.
    function automatic int onehot_to_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/luma_flux_scheduler_rr_pick.sv
// Rotating priority encoder: first set req bit after 'last', wrapping, 'last' lowest.
module rr_pick
    import luma_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] last,
    output logic                 found,
    output logic [TAG_WIDTH-1:0] idx
);

    logic [TAG_WIDTH-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = last;
        for (int k = 0; k < FLUX; k++) begin
            cand = (cand == TAG_WIDTH'(FLUX - 1)) ? '0 : cand + TAG_WIDTH'(1);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/luma_flux_scheduler.sv
// Round-robin burst scheduler selecting which tagged flux the interpolation actor serves.
module luma_flux_scheduler
    import luma_sched_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int BURST     = 4,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [FLUX-1:0]      req,
    input  logic                 fire,
    output logic [FLUX-1:0]      grant,
    output logic                 grant_valid,
    output logic [TAG_WIDTH-1:0] tag,
    output logic                 err
);

    localparam int CW = $clog2(BURST + 1);

    sched_state_t         state_q, state_d;
    logic [TAG_WIDTH-1:0] g_q, g_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0] last_q, last_d;
    logic                 err_q, err_d;
    logic [FLUX-1:0]      grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;
    logic [TAG_WIDTH-1:0] pick_last;
    logic                 req_g;
    logic                 release_now;

    // In HOLD the only pick that matters is the re-pick on release, where the
    // updated 'last' equals the currently granted flux.
    assign pick_last = (state_q == HOLD) ? g_q : last_q;

    rr_pick #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_rr_pick (
        .req   (req),
        .last  (pick_last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign req_g       = req[g_q];
    assign release_now = (fire && req_g && cnt_q == CW'(1)) || !req_g;

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        err_d         = err_q;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        tag_d         = '0;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    err_d = 1'b1;
                end
                if (pick_found) begin
                    state_d = HOLD;
                    g_d     = pick_idx;
                    cnt_d   = CW'(BURST);
                end
            end
            HOLD: begin
                if (fire && !req_g) begin
                    err_d = 1'b1;
                end
                if (fire && req_g) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (release_now) begin
                    last_d = g_q;
                    if (pick_found) begin
                        g_d   = pick_idx;
                        cnt_d = CW'(BURST);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == HOLD) begin
            grant_valid_d = 1'b1;
            grant_d[g_d]  = 1'b1;
            tag_d         = g_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            g_q           <= '0;
            cnt_q         <= '0;
            last_q        <= TAG_WIDTH'(FLUX - 1);
            err_q         <= 1'b0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            tag_q         <= '0;
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            err_q         <= err_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            tag_q         <= tag_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign tag         = tag_q;
    assign err         = err_q;

    always @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(grant_q));
            assert (!grant_valid_q || (grant_q == (FLUX'(1) << tag_q)));
            assert (!grant_valid_q || (onehot_to_idx(32'(grant_q)) == int'(tag_q)));
            assert (cnt_q <= CW'(BURST));
        end
    end

endmodule

// File: tb/tb_luma_flux_scheduler.sv
// Scoreboard bench: stimulus pushes expected post-edge outputs, monitor pops and compares.
module tb_luma_flux_scheduler;

    localparam int FLUX = 2;
    localparam int BURST = 4;
    localparam int TW = 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [FLUX-1:0] req = '0;
    logic            fire = 1'b0;
    logic [FLUX-1:0] grant;
    logic            grant_valid;
    logic [TW-1:0]   tag;
    logic            err;

    typedef struct {
        string         name;
        logic          gv;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    luma_flux_scheduler #(
        .FLUX  (FLUX),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .fire        (fire),
        .grant       (grant),
        .grant_valid (grant_valid),
        .tag         (tag),
        .err         (err)
    );

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input string name, input logic rst, input logic [FLUX-1:0] r,
                        input logic f, input logic egv, input logic [TW-1:0] etag,
                        input logic eerr);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        fire  = f;
        e.name = name;
        e.gv   = egv;
        e.tag  = etag;
        e.err  = eerr;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [FLUX-1:0] egrant;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                egrant = e.gv ? (FLUX'(1) << e.tag) : '0;
                checks++;
                if (grant_valid !== e.gv || tag !== e.tag || err !== e.err || grant !== egrant) begin
                    errors++;
                    $display("FAIL %s: got gv=%b tag=%0d grant=%b err=%b, need gv=%b tag=%0d grant=%b err=%b",
                             e.name, grant_valid, tag, grant, err, e.gv, e.tag, egrant, e.err);
                end else begin
                    $display("check %s: gv=%b tag=%0d grant=%b err=%b ok",
                             e.name, grant_valid, tag, grant, err);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        // 1: reset held with both fluxes requesting, then flux 0 wins first
        for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("first_grant", 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);

        // 2: back-to-back bursts of 4 alternating fluxes, no bubble
        step("burst_a1", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("burst_a2", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("burst_a3", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("switch_to_1", 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step("burst_b1", 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step("burst_b2", 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step("burst_b3", 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step("switch_to_0", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);

        // 3: partial burst then eligibility loss releases at the same edge
        step("partial_1", 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step("partial_2", 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step("elig_loss", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rr_after_0", 1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        step("drop_1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: sole requester re-granted across burst boundaries
        step("sole_grant", 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("sole_fire", 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        step("sole_drop", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: reset mid-burst on flux 1 with cnt=2
        step("mid_grant", 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mid_fire1", 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        step("mid_fire2", 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        step("mid_reset", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst_grant", 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
        step("full_b1", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("full_b2", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("full_b3", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        step("full_switch", 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        step("full_drop", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: fire in IDLE sets sticky err without leaving IDLE; reset clears it
        step("idle_fire", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        step("err_sticky1", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("err_sticky2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step("err_grant", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        step("err_reset", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step("err_cleared", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        step("fire_no_req", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
